lcd_rgb_timing_gen: RTL and testbench

// - Parametrised RGB parallel-LCD timing and test-pattern generator; successor to the fixed 800x480 RGB666 colour-bar top.
// - Generates HS/VS/DE with programmable porches, sync widths and polarity, plus selectable patterns or external pixel pass-through.
// - Sits between the PLL pixel clock and the LCD pins; a frame-buffer reader can attach to the external pixel port.

---
 rtl/lcd_rgb_timing_gen.sv | 155 +++++++++++++++
 tb/tb_lcd_rgb_timing_gen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/lcd_rgb_timing_gen.sv
// RGB parallel-LCD timing and test-pattern generator (HS/VS/DE, colour bar, gradient, checker, external).
// Define LCD_GEN_FRAME_CNT_EN to add the frame_cnt output and scrolling gradient/checker patterns.
module lcd_rgb_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 210,
   parameter int H_SYNC   = 1,
   parameter int H_BP     = 182,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 45,
   parameter int V_SYNC   = 1,
   parameter int V_BP     = 8,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int COLOR_W  = 6,
   parameter int CNT_W    = 12,
   parameter int CHK_LOG2 = 5
) (
   input  logic                 oscout,
   input  logic                 reset_n,
   input  logic [1:0]           mode,
   input  logic [3*COLOR_W-1:0] pix_in,
   output logic                 pix_req,
   output logic                 lcd_hs,
   output logic                 lcd_vs,
   output logic                 lcd_de,
   output logic [COLOR_W-1:0]   r_out,
   output logic [COLOR_W-1:0]   g_out,
   output logic [COLOR_W-1:0]   b_out,
   output logic [CNT_W-1:0]     pix_x,
   output logic [CNT_W-1:0]     pix_y,
`ifdef LCD_GEN_FRAME_CNT_EN
   output logic [7:0]           frame_cnt,
`endif
   output logic                 frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] BAR_WC   = CNT_W'(BAR_W);
   localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(7);

   logic [CNT_W-1:0]   h_cnt;
   logic [CNT_W-1:0]   v_cnt;
   logic [1:0]         mode_q;
   logic [1:0]         mode_eff;
   logic               first;
   logic               active;
   logic               hs_on;
   logic               vs_on;
   logic [CNT_W-1:0]   x_pat;
   logic [CNT_W-1:0]   bar_num;
   logic [2:0]         bar_idx;
   logic               chk;
   logic [COLOR_W-1:0] r_nxt;
   logic [COLOR_W-1:0] g_nxt;
   logic [COLOR_W-1:0] b_nxt;

   // Mode is taken live at (0,0) so the first pixel of a frame already uses the new mode.
   assign first    = (h_cnt == '0) && (v_cnt == '0);
   assign mode_eff = first ? mode : mode_q;
   assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_on    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign vs_on    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
   assign pix_req  = active && (mode_eff == 2'd3);

`ifdef LCD_GEN_FRAME_CNT_EN
   logic [7:0] scroll;
   // At (0,0) frame_cnt is about to step, so use the value this frame will carry.
   assign scroll = first ? frame_cnt + 8'd1 : frame_cnt;
   assign x_pat  = h_cnt + CNT_W'(scroll);
`else
   assign x_pat  = h_cnt;
`endif

   assign bar_num = h_cnt / BAR_WC;
   assign bar_idx = (bar_num > BAR_LAST) ? 3'd7 : bar_num[2:0];
   assign chk     = x_pat[CHK_LOG2] ^ v_cnt[CHK_LOG2];

   always_comb begin
      r_nxt = '0;
      g_nxt = '0;
      b_nxt = '0;
      if (active) begin
         unique case (mode_eff)
            2'd0: begin
               r_nxt = {COLOR_W{~bar_idx[1]}};
               g_nxt = {COLOR_W{~bar_idx[2]}};
               b_nxt = {COLOR_W{~bar_idx[0]}};
            end
            2'd1: begin
               r_nxt = x_pat[COLOR_W-1:0];
               g_nxt = v_cnt[COLOR_W-1:0];
               b_nxt = ~x_pat[COLOR_W-1:0];
            end
            2'd2: begin
               r_nxt = {COLOR_W{~chk}};
               g_nxt = {COLOR_W{~chk}};
               b_nxt = {COLOR_W{~chk}};
            end
            default: {r_nxt, g_nxt, b_nxt} = pix_in;
         endcase
      end
   end

   always_ff @(posedge oscout) begin
      if (!reset_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         mode_q      <= 2'd0;
         lcd_de      <= 1'b0;
         lcd_hs      <= ~HS_POL;
         lcd_vs      <= ~VS_POL;
         r_out       <= '0;
         g_out       <= '0;
         b_out       <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
`ifdef LCD_GEN_FRAME_CNT_EN
         frame_cnt   <= 8'd0;
`endif
      end else begin
         mode_q <= mode_eff;
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
         end else begin
            h_cnt <= h_cnt + CNT_W'(1);
         end
         lcd_de      <= active;
         lcd_hs      <= hs_on ? HS_POL : ~HS_POL;
         lcd_vs      <= vs_on ? VS_POL : ~VS_POL;
         r_out       <= r_nxt;
         g_out       <= g_nxt;
         b_out       <= b_nxt;
         pix_x       <= h_cnt;
         pix_y       <= v_cnt;
         frame_start <= first;
`ifdef LCD_GEN_FRAME_CNT_EN
         if (first) frame_cnt <= frame_cnt + 8'd1;
`endif
      end
   end

endmodule

// File: tb/tb_lcd_rgb_timing_gen.sv
// Scoreboard bench for lcd_rgb_timing_gen with a 22x7 reduced timing (16/2/2/2, 4/1/1/1).
module tb_lcd_rgb_timing_gen;

   logic        oscout = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [17:0] pix_in = '0;
   logic        pix_req, lcd_hs, lcd_vs, lcd_de, frame_start;
   logic [5:0]  r_out, g_out, b_out;
   logic [11:0] pix_x, pix_y;
`ifdef LCD_GEN_FRAME_CNT_EN
   logic [7:0]  frame_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   lcd_rgb_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(6), .CNT_W(12), .CHK_LOG2(2)
   ) dut (
      .oscout(oscout), .reset_n(reset_n), .mode(mode), .pix_in(pix_in),
      .pix_req(pix_req), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
      .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .pix_x(pix_x), .pix_y(pix_y),
`ifdef LCD_GEN_FRAME_CNT_EN
      .frame_cnt(frame_cnt),
`endif
      .frame_start(frame_start)
   );

   always #5 oscout = ~oscout;

   // Reference model state and scoreboard of expected registered outputs.
   int          mh = 0;
   int          mv = 0;
   logic [1:0]  mmode = 2'd0;
   logic [45:0] sb[$];
   logic [17:0] bar_tab[8] = '{18'h3FFFF, 18'h3FFC0, 18'h00FFF, 18'h00FC0,
                               18'h3F03F, 18'h3F000, 18'h0003F, 18'h00000};
   int          cyc = 0;
   int          fs_last = 0;
   bit          fs_valid = 0;
   int          de_run = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic step(input logic rst, input logic [1:0] md, input logic [17:0] pin);
      logic [45:0] act_v;
      logic [45:0] exp_v;
      logic [1:0]  em;
      logic        act;
      logic [17:0] rgb;
      @(negedge oscout);
      cyc++;
      act_v = {lcd_de, lcd_hs, lcd_vs, frame_start, r_out, g_out, b_out, pix_x, pix_y};
      if (sb.size() > 0) begin
         exp_v = sb.pop_front();
         check("outputs", act_v, exp_v);
      end
      if (frame_start === 1'b1) begin
         if (fs_valid) check("frame_period", cyc - fs_last, 154);
         fs_last  = cyc;
         fs_valid = 1;
      end
      if (lcd_de === 1'b1) de_run++;
      else if (de_run != 0) begin
         check("de_run", de_run, 16);
         de_run = 0;
      end
      if (!rst) begin
         fs_valid = 0;
         de_run   = 0;
      end
      reset_n = rst;
      mode    = md;
      pix_in  = pin;
      #1;
      em  = (mh == 0 && mv == 0) ? md : mmode;
      act = (mh < 16) && (mv < 4);
      check("pix_req", pix_req, act && em == 2'd3);
      if (!rst) begin
         sb.push_back({1'b0, 1'b1, 1'b1, 1'b0, 18'h0, 12'h0, 12'h0});
         mh = 0;
         mv = 0;
         mmode = 2'd0;
      end else begin
         rgb = '0;
         if (act) begin
            case (em)
               2'd0: rgb = bar_tab[mh / 2];
               2'd1: rgb = {6'(mh), 6'(mv), ~6'(mh)};
               2'd2: rgb = (((mh >> 2) ^ (mv >> 2)) & 1) != 0 ? 18'h0 : 18'h3FFFF;
               default: rgb = pin;
            endcase
         end
         sb.push_back({act, !(mh >= 18 && mh < 20), !(mv == 5), (mh == 0 && mv == 0),
                       rgb, 12'(mh), 12'(mv)});
         mmode = em;
         if (mh == 21) begin
            mh = 0;
            mv = (mv == 6) ? 0 : mv + 1;
         end else begin
            mh++;
         end
      end
   endtask

   initial begin
      repeat (3) step(1'b0, 2'd0, 18'h0);
      repeat (2 * 154) step(1'b1, 2'd0, 18'h0);
      // Switch to checker mid-frame: the bar must persist to the frame end.
      repeat (60) step(1'b1, 2'd0, 18'h0);
      repeat (2 * 154) step(1'b1, 2'd2, 18'h0);
      repeat (2 * 154) step(1'b1, 2'd1, 18'h0);
      repeat (2 * 154) step(1'b1, 2'd3, 18'h2AAAA);
      repeat (154) step(1'b1, 2'd3, 18'($urandom));
      for (int i = 0; i < 200 && !(mh == 7 && mv == 2); i++) step(1'b1, 2'd0, 18'h0);
      check("reset_point", {mh[15:0], mv[15:0]}, {16'd7, 16'd2});
      repeat (2) step(1'b0, 2'd0, 18'h0);
      repeat (2 * 154 + 2) step(1'b1, 2'd0, 18'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
